hypot_rr_arbiter: RTL and testbench

//  Shares one hypotenuse unit (y = floor(sqrt(a*a + b*b)), 8-bit in/out, start/ready/busy handshake) among N_REQ requesters.

---
 rtl/hypot_pkg.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/hypot_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_hypot_rr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hypot_pkg.sv
// Shared definitions for the hypotenuse-unit arbiter: FSM state encoding and default widths.
package hypot_pkg;

  localparam int W_DEF  = 8;
  localparam int WDOG_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACCEPT = 2'd2,
    RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping to 0.
module rr_pick
  import hypot_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index,
  output logic             any
);

  int idx;

  // Scan from the farthest offset back to ptr so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        index      = IW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hypot_rr_arbiter.sv
// Round-robin front end sharing one hypotenuse unit among N_REQ requesters.
// Optional watchdog: define HYPOT_ARB_TIMEOUT_EN to abort requests stuck in ACCEPT/RUN.
module hypot_rr_arbiter
  import hypot_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = W_DEF,
  parameter int TMO_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_y,
  output logic               rsp_err,
  output logic               unit_start,
  output logic [W-1:0]       unit_a,
  output logic [W-1:0]       unit_b,
  input  logic               unit_ready,
  input  logic               unit_busy,
  input  logic [W-1:0]       unit_y
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

`ifdef HYPOT_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] cur);
    if (cur == IW'(N_REQ - 1)) return '0;
    return cur + IW'(1);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_y      <= '0;
      rsp_err    <= 1'b0;
      unit_start <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
`ifdef HYPOT_ARB_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      unit_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any && unit_ready) begin
            unit_a  <= req_a[int'(pick_idx)*W +: W];
            unit_b  <= req_b[int'(pick_idx)*W +: W];
            owner   <= pick_idx;
            req_ack <= pick_grant;
            state   <= START;
          end
        end
        START: begin
          unit_start <= 1'b1;
          state      <= ACCEPT;
        end
        ACCEPT: begin
          if (unit_busy) state <= RUN;
        end
        RUN: begin
          if (!unit_busy) begin
            rsp_y     <= unit_y;
            rsp_valid <= onehot(owner);
            ptr       <= next_ptr(owner);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef HYPOT_ARB_TIMEOUT_EN
      // A normal completion in RUN takes priority over a watchdog expiring in the same cycle.
      if (state == ACCEPT || state == RUN) begin
        if (state == RUN && !unit_busy) begin
          wdog <= '0;
        end else if (wdog == WDOG_W'(TMO_CYC - 1)) begin
          wdog      <= '0;
          rsp_valid <= onehot(owner);
          rsp_err   <= 1'b1;
          rsp_y     <= '0;
          ptr       <= next_ptr(owner);
          state     <= IDLE;
        end else begin
          wdog <= wdog + WDOG_W'(1);
        end
      end else begin
        wdog <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_hypot_rr_arbiter.sv
// Scoreboard bench for hypot_rr_arbiter wrapped around a behavioural hypotenuse unit.
module tb_hypot_rr_arbiter;

  localparam int N   = 4;
  // sqrt(2)*255 = 360 needs nine bits, so the block runs at W=9 with operands kept in 0..255.
  localparam int W   = 9;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ack, rsp_valid;
  logic [W-1:0]   rsp_y, unit_a, unit_b, unit_y;
  logic           rsp_err, unit_start, unit_ready, unit_busy;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic         rv   [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rv[i];
      req_a[i*W +: W]    = op_a[i];
      req_b[i*W +: W]    = op_b[i];
    end
  end

  hypot_rr_arbiter #(.N_REQ(N), .W(W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_ready(unit_ready), .unit_busy(unit_busy), .unit_y(unit_y)
  );

  function automatic int isqrt(input int s);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int hyp(input int a, input int b);
    return isqrt(a * a + b * b);
  endfunction

  // Behavioural shared unit: random busy time, optional stall that never releases busy.
  logic [W-1:0] ua_l, ub_l;
  int           ucnt;
  bit           stall = 1'b0;
  assign unit_ready = ~unit_busy;
  always @(posedge clk) begin
    if (rst) begin
      unit_busy <= 1'b0;
      unit_y    <= '0;
      ucnt      <= 0;
    end else if (!unit_busy) begin
      if (unit_start) begin
        unit_busy <= 1'b1;
        ucnt      <= int'($urandom_range(0, 5));
        ua_l      <= unit_a;
        ub_l      <= unit_b;
      end
    end else if (!stall) begin
      if (ucnt == 0) begin
        unit_busy <= 1'b0;
        unit_y    <= W'(hyp(int'(ua_l), int'(ub_l)));
      end else begin
        ucnt <= ucnt - 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int idx;
    int y;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   y_log[$];
  int   err_log[$];
  bit   expect_tmo = 1'b0;
  int   n_start = 0;

  // Reference arbitration: first pending requester at or after the pointer.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  logic [N-1:0] pv;
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  bit           pack;
  int           mptr, e_idx, exp_ua, exp_ub;
  exp_t         ex;

  initial begin
    pv = '0; pack = 1'b0; mptr = 0; exp_ua = 0; exp_ub = 0;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mptr = 0;
        pack = 1'b0;
      end else begin
        if (unit_start) n_start++;
        if (pack) begin
          check("start_latency", int'(unit_start), 1);
          check("unit_a", int'(unit_a), exp_ua);
          check("unit_b", int'(unit_b), exp_ub);
        end else begin
          check("start_idle", int'(unit_start), 0);
        end
        pack = 1'b0;
        if (req_ack != '0) begin
          e_idx = model_pick(pv, mptr);
          if (e_idx < 0) begin
            check("ack_no_request", int'(req_ack), 0);
          end else begin
            check("ack_grant", int'(req_ack), 1 << e_idx);
            check("ack_rsp_overlap", int'(rsp_valid), 0);
            grant_log.push_back(e_idx);
            exp_ua = int'(pa[e_idx]);
            exp_ub = int'(pb[e_idx]);
            exp_q.push_back('{e_idx, expect_tmo ? 0 : hyp(exp_ua, exp_ub), int'(expect_tmo)});
            pack = 1'b1;
          end
        end
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", int'(rsp_valid), 0);
          end else begin
            ex = exp_q.pop_front();
            check("rsp_route", int'(rsp_valid), 1 << ex.idx);
            check("rsp_y", int'(rsp_y), ex.y);
            check("rsp_err", int'(rsp_err), ex.err);
            check("unit_a_hold", int'(unit_a), exp_ua);
            y_log.push_back(int'(rsp_y));
            err_log.push_back(int'(rsp_err));
            mptr = (ex.idx + 1) % N;
          end
        end
      end
      pv = req_valid;
      for (int i = 0; i < N; i++) begin pa[i] = op_a[i]; pb[i] = op_b[i]; end
    end
  end

  // One requester: raise valid, hold until ack, drop and scramble operands, repeat.
  task automatic drive(input int i, input int n, input int gap_max, input bit fixed,
                       input int a, input int b);
    int t;
    for (int r = 0; r < n; r++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      op_a[i] = fixed ? W'(a) : W'($urandom_range(0, 255));
      op_b[i] = fixed ? W'(b) : W'($urandom_range(0, 255));
      rv[i]   = 1'b1;
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (!req_ack[i] && t < 400);
      check("ack_wait", int'(req_ack[i]), 1);
      rv[i]   = 1'b0;
      op_a[i] = W'($urandom_range(0, 255));
      op_b[i] = W'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    repeat (3) begin @(posedge clk); #1; end
    while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
    check("drain", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ack"}, int'(req_ack), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_y"}, int'(rsp_y), 0);
    check({tag, "_rsp_err"}, int'(rsp_err), 0);
    check({tag, "_unit_start"}, int'(unit_start), 0);
    check({tag, "_unit_a"}, int'(unit_a), 0);
    check({tag, "_unit_b"}, int'(unit_b), 0);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    y_log.delete();
    err_log.delete();
  endtask

  task automatic expect_seq(input string name, input int act[$], input int exp[$]);
    check({name, "_count"}, act.size(), exp.size());
    for (int k = 0; k < exp.size() && k < act.size(); k++)
      check(name, act[k], exp[k]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  int s0, t6;

  initial begin
    for (int i = 0; i < N; i++) begin rv[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_zero("reset");
    rst = 1'b0;

    // Single request.
    clear_logs();
    s0 = n_start;
    drive(0, 1, 0, 1'b1, 3, 4);
    drain();
    expect_seq("t1_grant", grant_log, '{0});
    expect_seq("t1_y", y_log, '{5});
    check("t1_starts", n_start - s0, 1);

    // All four at once from pointer 0.
    pulse_reset();
    clear_logs();
    fork
      drive(0, 1, 0, 1'b1, 6, 8);
      drive(1, 1, 0, 1'b1, 5, 12);
      drive(2, 1, 0, 1'b1, 8, 15);
      drive(3, 1, 0, 1'b1, 0, 0);
    join
    drain();
    expect_seq("t2_grant", grant_log, '{0, 1, 2, 3});
    expect_seq("t2_y", y_log, '{10, 13, 17, 0});

    // Fairness: requester 0 re-requests at once, requester 2 keeps requesting.
    clear_logs();
    fork
      drive(0, 3, 0, 1'b0, 0, 0);
      drive(2, 3, 0, 1'b0, 0, 0);
    join
    drain();
    expect_seq("t3_grant", grant_log, '{0, 2, 0, 2, 0, 2});

    // Boundary operands; drive scrambles them right after ack.
    clear_logs();
    drive(1, 1, 0, 1'b1, 255, 255);
    drain();
    expect_seq("t4_y", y_log, '{360});

    // Reset while the unit is running; the request is abandoned.
    clear_logs();
    drive(2, 1, 0, 1'b1, 7, 24);
    s0 = 0;
    while (!unit_busy && s0 < 50) begin @(posedge clk); #1; s0++; end
    check("t5_busy_seen", int'(unit_busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("t5_rst");
    rst = 1'b0;
    clear_logs();
    fork
      drive(1, 1, 0, 1'b1, 3, 4);
      drive(3, 1, 0, 1'b1, 3, 4);
    join
    drain();
    expect_seq("t5_grant", grant_log, '{1, 3});
    expect_seq("t5_y", y_log, '{5, 5});

`ifdef HYPOT_ARB_TIMEOUT_EN
    // Watchdog: unit never drops busy; next grant waits for the unit to become ready.
    clear_logs();
    stall = 1'b1;
    expect_tmo = 1'b1;
    drive(0, 1, 0, 1'b1, 3, 4);
    t6 = 1;
    while (!rsp_valid[0] && t6 < 100) begin @(posedge clk); #1; t6++; end
    check("t6_latency", t6, TMO + 1);
    check("t6_err", int'(rsp_err), 1);
    expect_tmo = 1'b0;
    fork
      drive(1, 1, 0, 1'b1, 5, 12);
      begin
        repeat (6) begin @(posedge clk); #1; end
        check("t6_wait_ready", grant_log.size(), 1);
        stall = 1'b0;
      end
    join
    drain();
    expect_seq("t6_grant", grant_log, '{0, 1});
    expect_seq("t6_y", y_log, '{0, 13});
    expect_seq("t6_errs", err_log, '{1, 0});
`endif

    // Randomized traffic on all requesters.
    clear_logs();
    fork
      drive(0, 8, 4, 1'b0, 0, 0);
      drive(1, 8, 4, 1'b0, 0, 0);
      drive(2, 8, 4, 1'b0, 0, 0);
      drive(3, 8, 4, 1'b0, 0, 0);
    join
    drain();
    check("rand_served", y_log.size(), 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, got t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
